// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link receive path.
// Holds the FSM state encoding and the line levels that define a frame.
package serial_link_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StStart = 3'd1,
        StData  = 3'd2,
        StStop  = 3'd3,
        StBreak = 3'd4
    } state_e;

    localparam logic StartLevel = 1'b0;
    localparam logic StopLevel  = 1'b1;
    localparam logic IdleLevel  = 1'b1;

    function automatic int unsigned half_cycles(input int unsigned bit_cycles);
        return bit_cycles / 2;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Per-bit cycle counter. Flags the terminal count of either a half or a full bit
// period and restarts from zero after each terminal count.
module bit_timer
    import serial_link_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic half_sel,
    output logic done
);

    localparam int unsigned CntW = $clog2(BIT_CYCLES);
    localparam logic [CntW-1:0] HalfTerm = CntW'(half_cycles(BIT_CYCLES) - 1);
    localparam logic [CntW-1:0] FullTerm = CntW'(BIT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        done = (cnt_q == (half_sel ? HalfTerm : FullTerm));
        if (clear || done) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_deserializer.sv
// Recovers start/data/stop frames from a registered serial line and hands each
// word over through a valid/ready holding register with error and overrun pulses.
module serial_frame_deserializer
    import serial_link_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned MSB_FIRST  = 0
) (
    input  logic              Clk,
    input  logic              Resetn,
    input  logic              Din,
    input  logic              Dready,
    output logic [DATA_W-1:0] Dout,
    output logic              Dvalid,
    output logic              FrameErr,
    output logic              Overrun,
    output logic              Busy
);

    localparam int unsigned IdxW = $clog2(DATA_W + 1);

    state_e state_q, state_d;

    logic              timer_clear;
    logic              half_sel;
    logic              bit_done;
    logic              last_bit;
    logic              sample_bit;
    logic              stop_good;
    logic              stop_bad;
    logic [IdxW-1:0]   bit_idx_q;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] dout_q;
    logic              dvalid_q;
    logic              frame_err_q;
    logic              overrun_q;

    bit_timer #(
        .BIT_CYCLES (BIT_CYCLES)
    ) u_bit_timer (
        .clk      (Clk),
        .rst_n    (Resetn),
        .clear    (timer_clear),
        .half_sel (half_sel),
        .done     (bit_done)
    );

    assign last_bit = (bit_idx_q == IdxW'(DATA_W - 1));

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (Din == StartLevel) state_d = StStart;
            StStart: if (bit_done) state_d = (Din == StartLevel) ? StData : StIdle;
            StData:  if (bit_done && last_bit) state_d = StStop;
            StStop:  if (bit_done) state_d = (Din == StopLevel) ? StIdle : StBreak;
            StBreak: if (Din == IdleLevel) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        timer_clear = (state_q == StIdle) || (state_q == StBreak);
        half_sel    = (state_q == StStart);
        sample_bit  = (state_q == StData) && bit_done;
        stop_good   = (state_q == StStop) && bit_done && (Din == StopLevel);
        stop_bad    = (state_q == StStop) && bit_done && (Din != StopLevel);
        Busy        = (state_q != StIdle);
    end

    // Shift direction decides which end of Dout the first data bit lands in.
    if (DATA_W == 1) begin : g_shift_one
        assign shift_d = Din;
    end else if (MSB_FIRST != 0) begin : g_shift_msb
        assign shift_d = {shift_q[DATA_W-2:0], Din};
    end else begin : g_shift_lsb
        assign shift_d = {Din, shift_q[DATA_W-1:1]};
    end

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else begin
            if (half_sel && bit_done) begin
                bit_idx_q <= '0;
            end else if (sample_bit) begin
                shift_q   <= shift_d;
                bit_idx_q <= bit_idx_q + 1'b1;
            end
        end
    end

    // A consumer taking the old word in the stop-sample cycle frees the slot.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            dout_q      <= '0;
            dvalid_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= stop_bad;
            overrun_q   <= stop_good && dvalid_q && !Dready;
            if (stop_good && (!dvalid_q || Dready)) begin
                dout_q   <= shift_q;
                dvalid_q <= 1'b1;
            end else if (dvalid_q && Dready) begin
                dvalid_q <= 1'b0;
            end
        end
    end

    assign Dout     = dout_q;
    assign Dvalid   = dvalid_q;
    assign FrameErr = frame_err_q;
    assign Overrun  = overrun_q;

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Directed and randomized frames against a transaction-level model of the
// receive handshake; every cycle checks the outputs against the model.
module tb_serial_frame_deserializer;

    localparam int unsigned DW = 8;
    localparam int unsigned BC = 4;

    logic          Clk;
    logic          Resetn;
    logic          Din;
    logic          Dready;
    logic [DW-1:0] Dout;
    logic          Dvalid;
    logic          FrameErr;
    logic          Overrun;
    logic          Busy;

    int tests = 0;
    int fails = 0;

    // Reference model: holding register contents and expected pulses.
    bit          mv;
    logic [DW-1:0] md;
    bit          exp_fe;
    bit          exp_ov;
    bit          stop_edge;
    bit          stop_good;
    logic [DW-1:0] stop_word;

    serial_frame_deserializer #(
        .DATA_W     (DW),
        .BIT_CYCLES (BC),
        .MSB_FIRST  (0)
    ) dut (
        .Clk      (Clk),
        .Resetn   (Resetn),
        .Din      (Din),
        .Dready   (Dready),
        .Dout     (Dout),
        .Dvalid   (Dvalid),
        .FrameErr (FrameErr),
        .Overrun  (Overrun),
        .Busy     (Busy)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the model decides what the edge must do before it happens.
    task automatic tick();
        bit deliver;
        exp_fe  = 1'b0;
        exp_ov  = 1'b0;
        deliver = 1'b0;
        if (Resetn) begin
            if (stop_edge && !stop_good) exp_fe = 1'b1;
            if (stop_edge && stop_good) begin
                if (!mv || Dready) deliver = 1'b1;
                else exp_ov = 1'b1;
            end
            if (deliver) begin
                mv = 1'b1;
                md = stop_word;
            end else if (mv && Dready) begin
                mv = 1'b0;
            end
        end
        stop_edge = 1'b0;
        @(posedge Clk);
        #1;
        check("dvalid", Dvalid, mv);
        check("dout", Dout, md);
        check("frame_err", FrameErr, exp_fe);
        check("overrun", Overrun, exp_ov);
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            Din = w[i];
            repeat (BC) tick();
        end
    endtask

    // ready_at_stop < 0 leaves Dready alone; otherwise Dready takes that value
    // only for the stop-sample edge.
    task automatic send_frame(input logic [DW-1:0] w, input bit stop, input int ready_at_stop);
        logic saved;
        Din = 1'b0;
        repeat (BC) tick();
        check("busy_in_frame", Busy, 1);
        send_bits(w, DW);
        Din = stop;
        tick();
        tick();
        stop_edge = 1'b1;
        stop_good = stop;
        stop_word = w;
        saved = Dready;
        if (ready_at_stop >= 0) Dready = ready_at_stop[0];
        tick();
        Dready = saved;
        tick();
        check("busy_after_stop", Busy, !stop);
    endtask

    initial begin
        mv        = 1'b0;
        md        = '0;
        stop_edge = 1'b0;
        stop_good = 1'b0;
        stop_word = '0;
        Resetn    = 1'b0;
        Din       = 1'b1;
        Dready    = 1'b1;

        repeat (2) @(posedge Clk);
        #1;
        check("rst_dvalid", Dvalid, 0);
        check("rst_dout", Dout, 0);
        check("rst_frame_err", FrameErr, 0);
        check("rst_overrun", Overrun, 0);
        check("rst_busy", Busy, 0);
        Resetn = 1'b1;
        repeat (3) tick();

        // 1: basic frame, Dvalid exactly one cycle after the stop sample
        send_frame(8'hA5, 1'b1, -1);
        repeat (2) tick();

        // 2: one-cycle glitch rejected in START
        Din = 1'b0;
        tick();
        check("glitch_busy0", Busy, 1);
        Din = 1'b1;
        tick();
        check("glitch_busy1", Busy, 1);
        tick();
        check("glitch_busy2", Busy, 0);
        repeat (3) tick();

        // 3: bad stop bit, line held low, then recovery
        send_frame(8'h3C, 1'b0, -1);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("break_busy", Busy, 1);
        end
        Din = 1'b1;
        tick();
        check("break_exit", Busy, 0);
        repeat (2) tick();
        send_frame(8'h11, 1'b1, -1);
        repeat (2) tick();

        // 4: overrun while the holding register is full
        Dready = 1'b0;
        send_frame(8'h12, 1'b1, -1);
        repeat (2) tick();
        send_frame(8'h34, 1'b1, -1);
        repeat (2) tick();
        Dready = 1'b1;
        repeat (3) tick();

        // 5: asynchronous reset in the middle of a frame
        Dready = 1'b0;
        send_frame(8'h77, 1'b1, -1);
        Din = 1'b0;
        repeat (BC) tick();
        send_bits(8'hFF, 4);
        tick();
        #2;
        Resetn = 1'b0;
        mv = 1'b0;
        md = '0;
        #1;
        check("async_dvalid", Dvalid, 0);
        check("async_dout", Dout, 0);
        check("async_busy", Busy, 0);
        check("async_frame_err", FrameErr, 0);
        check("async_overrun", Overrun, 0);
        Din = 1'b1;
        repeat (2) tick();
        Resetn = 1'b1;
        Dready = 1'b1;
        repeat (2) tick();
        send_frame(8'h5A, 1'b1, -1);
        repeat (2) tick();

        // 6: consumer takes the old word in the stop-sample cycle of the next
        Dready = 1'b0;
        send_frame(8'h01, 1'b1, -1);
        tick();
        send_frame(8'h02, 1'b1, 1);
        repeat (2) tick();
        Dready = 1'b1;
        repeat (2) tick();

        // Randomized frames, stop errors, gaps and back-pressure
        for (int n = 0; n < 25; n++) begin
            logic [DW-1:0] w;
            bit            st;
            w      = DW'($urandom);
            st     = ($urandom_range(0, 5) != 0);
            Dready = ($urandom_range(0, 3) != 0);
            Din    = 1'b1;
            repeat ($urandom_range(0, 3)) tick();
            send_frame(w, st, -1);
            if (!st) begin
                repeat ($urandom_range(0, 4)) tick();
                Din = 1'b1;
                tick();
                check("rand_break_exit", Busy, 0);
            end
        end
        Din    = 1'b1;
        Dready = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
